// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with start/done handshake
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // One guard bit so unsigned operands and the most-negative signed value stay exact.
  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   m, acc, q;
  logic           q_1;
  logic [CW-1:0]  count;

  logic [N-1:0]   a_ext, b_ext;
  logic [N-1:0]   acc_step, acc_sh, q_sh;
  logic           q_1_sh;
  logic           accept, last;

  assign a_ext = {is_signed & a[WIDTH-1], a};
  assign b_ext = {is_signed & b[WIDTH-1], b};

  // One Booth step: add/subtract the multiplicand, then arithmetic shift of {A,Q,q_1}.
  always_comb begin
    acc_step = acc;
    case ({q[0], q_1})
      2'b10:   acc_step = acc - m;
      2'b01:   acc_step = acc + m;
      default: acc_step = acc;
    endcase
    acc_sh = {acc_step[N-1], acc_step[N-1:1]};
    q_sh   = {acc_step[0], q[N-1:1]};
    q_1_sh = q[0];
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control decode; busy comes straight from the state register.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == CW'(N - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result publication on the final step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        m     <= a_ext;
        q     <= b_ext;
        acc   <= '0;
        q_1   <= 1'b0;
        count <= '0;
      end else if (state == RUN) begin
        acc   <= acc_sh;
        q     <= q_sh;
        q_1   <= q_1_sh;
        count <= count + 1'b1;
        if (last) begin
          // Low 2*WIDTH bits of the 2*N-bit {A,Q} are the exact product.
          {hi, lo} <= {acc_sh[N-3:0], q_sh};
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - directed-vector bench for booth_mult_seq
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, sgn;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;
  logic        start8, sgn8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8;

  int n_vec = 0;
  int n_err = 0;

  booth_mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .is_signed(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run32(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el);
    int lat, nb;
    a = av; b = bv; sgn = s; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0; nb = 0;
    while (!done && lat < 60) begin
      if (busy) nb++;
      tick;
      lat++;
    end
    check({tag, "_lat"}, lat, 33);
    check({tag, "_busy"}, nb, 33);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    tick;
    check({tag, "_pulse"}, done, 1'b0);
  endtask

  task automatic run8(input string tag, input logic s, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] eh, input logic [7:0] el);
    int lat;
    a8 = av; b8 = bv; sgn8 = s; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      tick;
      lat++;
    end
    check({tag, "_lat"}, lat, 9);
    check({tag, "_hi"}, hi8, eh);
    check({tag, "_lo"}, lo8, el);
    tick;
  endtask

  initial begin
    int lat, ndone, bad;
    reset = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    tick; tick;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_hilo8", {hi8, lo8}, 16'h0);
    reset = 1'b0;
    tick;

    run32("neg7x3",  1'b1, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run32("ffff_u",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run32("ffff_s",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run32("min_s",   1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run32("min_u",   1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

    // Start ignored while busy; operand changes mid-run have no effect.
    a = 32'd5; b = 32'd6; sgn = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0; ndone = 0;
    while (!done && lat < 60) begin
      if (lat == 9) begin
        start = 1'b1; a = 32'd100; b = 32'd100; sgn = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick;
      lat++;
    end
    check("busy_start_lat", lat, 33);
    check("busy_start_res", {hi, lo}, 64'h1E);
    repeat (40) begin
      tick;
      if (done) ndone++;
    end
    check("busy_start_single", ndone, 0);

    // Start held high through done: second operation accepted in the done cycle.
    a = 32'd5; b = 32'd6; sgn = 1'b0; start = 1'b1;
    tick;
    lat = 0;
    while (!done && lat < 60) begin
      tick;
      lat++;
    end
    check("b2b_first_res", {hi, lo}, 64'h1E);
    a = 32'd7; b = 32'd3;
    tick;
    start = 1'b0;
    lat = 0; bad = 0;
    while (!done && lat < 60) begin
      if ({hi, lo} !== 64'h1E) bad++;
      tick;
      lat++;
    end
    check("b2b_hold", bad, 0);
    check("b2b_lat", lat, 33);
    check("b2b_res", {hi, lo}, 64'h15);
    tick;

    // Asynchronous reset in the middle of an operation.
    a = 32'h12345678; b = 32'h9ABCDEF0; sgn = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_hilo", {hi, lo}, 64'h0);
    tick;
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      tick;
      if (done) ndone++;
    end
    check("mid_rst_nodone", ndone, 0);
    check("mid_rst_hold", {hi, lo}, 64'h0);

    run32("after_rst", 1'b0, 32'd5, 32'd6, 32'h0, 32'h1E);

    run8("w8_u", 1'b0, 8'hFF, 8'h02, 8'h01, 8'hFE);
    run8("w8_s", 1'b1, 8'hFF, 8'h02, 8'hFF, 8'hFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
